// File: rtl/scrambler_pkg.sv
// rtl/scrambler_pkg.sv - shared types, constants and feedback function for the 12-bit additive scrambler family
//
// Purpose : common definitions used by the transmit scrambler, the
//           lfsr12_step helper and descrambler_sync.
// Contents: LFSR_W, TAP_MASK, DEFAULT_SEED, dsc_state_t, lfsr_fb().

package scrambler_pkg;

  localparam int LFSR_W = 12;

  // Feedback taps at bits 10, 3 and 0.
  localparam logic [LFSR_W-1:0] TAP_MASK = 12'b0100_0000_1001;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 12'h14D;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } dsc_state_t;

  // Feedback bit of the LFSR; this is also the keystream bit for the
  // current position in the sequence.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] state);
    return ^(state & TAP_MASK);
  endfunction

endpackage : scrambler_pkg

// File: rtl/lfsr12_step.sv
// rtl/lfsr12_step.sv - combinational one-step advance of the 12-bit scrambler LFSR
//
// Purpose : produces the feedback/keystream bit for the current LFSR value
//           and the LFSR value after one shift. Shared by the scrambler and
//           descrambler so both ends advance identically.
// Ports   :
//   state_i  in  [11:0]  current LFSR value
//   fb_o     out         feedback bit (keystream bit for this position)
//   next_o   out [11:0]  LFSR value after one shift: {fb, state[11:1]}

module lfsr12_step
  import scrambler_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic              fb_o,
  output logic [LFSR_W-1:0] next_o
);

  assign fb_o   = lfsr_fb(state_i);
  assign next_o = {fb_o, state_i[LFSR_W-1:1]};

endmodule : lfsr12_step

// File: rtl/descrambler_sync.sv
// rtl/descrambler_sync.sv - self-synchronising receive descrambler for the 12-bit additive scrambler
//
// Purpose : removes the additive keystream from the received serial bits.
//           Alignment comes either from the shared reset seed (START_LOCKED)
//           or from hunting on an all-zero idle preamble: with zero
//           plaintext the last 12 line bits equal the transmitter LFSR, so
//           they are captured, then VERIFY_LEN further bits are predicted
//           before declaring lock.
// Ports   :
//   CLK_I     in   clock
//   RST_N_I   in   asynchronous active-low reset
//   BIT_I     in   received scrambled bit, qualified by VALID_I
//   VALID_I   in   BIT_I valid this cycle (no backpressure)
//   RESYNC_I  in   single-cycle pulse, forces re-acquisition (HUNT)
//   BIT_O     out  descrambled bit, registered
//   VALID_O   out  BIT_O valid, registered, one cycle after VALID_I
//   LOCK_O    out  high while in LOCKED, registered

module descrambler_sync
  import scrambler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED         = DEFAULT_SEED,
  parameter bit                START_LOCKED = 1'b1,
  parameter int unsigned       VERIFY_LEN   = 16
) (
  input  logic CLK_I,
  input  logic RST_N_I,
  input  logic BIT_I,
  input  logic VALID_I,
  input  logic RESYNC_I,
  output logic BIT_O,
  output logic VALID_O,
  output logic LOCK_O
);

  localparam dsc_state_t RESET_STATE  = START_LOCKED ? LOCKED : HUNT;
  localparam logic [7:0] HUNT_LAST    = 8'(LFSR_W - 1);
  localparam logic [7:0] VERIFY_LEN_C = VERIFY_LEN[7:0];

  dsc_state_t        state_q,  state_d;
  logic [LFSR_W-1:0] lfsr_q,   lfsr_d;
  // The oldest hunt bit is shifted out on the same cycle the capture is
  // taken, so bit 0 is never stored.
  logic [LFSR_W-1:1] hunt_sr_q, hunt_sr_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic              bit_o_q,   bit_o_d;
  logic              valid_o_q, valid_o_d;
  logic              lock_o_q,  lock_o_d;

  logic              fb;
  logic [LFSR_W-1:0] lfsr_step;
  logic [LFSR_W-1:0] hunt_capture;
  logic [7:0]        cnt_inc;

  lfsr12_step u_step (
    .state_i (lfsr_q),
    .fb_o    (fb),
    .next_o  (lfsr_step)
  );

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q   <= RESET_STATE;
      lfsr_q    <= SEED;
      hunt_sr_q <= '0;
      bit_cnt_q <= '0;
      bit_o_q   <= 1'b0;
      valid_o_q <= 1'b0;
      lock_o_q  <= START_LOCKED;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      hunt_sr_q <= hunt_sr_d;
      bit_cnt_q <= bit_cnt_d;
      bit_o_q   <= bit_o_d;
      valid_o_q <= valid_o_d;
      lock_o_q  <= lock_o_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    hunt_sr_d = hunt_sr_q;
    bit_cnt_d = bit_cnt_q;
    bit_o_d   = bit_o_q;
    valid_o_d = 1'b0;

    // Newest bit enters at the MSB, matching how the transmitter shifts its
    // feedback in; after 12 idle bits this equals the transmitter LFSR.
    hunt_capture = {BIT_I, hunt_sr_q};
    cnt_inc      = bit_cnt_q + 8'd1;

    if (RESYNC_I) begin
      state_d   = HUNT;
      hunt_sr_d = '0;
      bit_cnt_d = '0;
    end else if (VALID_I) begin
      case (state_q)
        HUNT: begin
          hunt_sr_d = hunt_capture[LFSR_W-1:1];
          if (bit_cnt_q == HUNT_LAST) begin
            bit_cnt_d = '0;
            // An all-zero capture would lock the LFSR at zero forever;
            // discard it and hunt a fresh 12 bits.
            if (hunt_capture != '0) begin
              lfsr_d  = hunt_capture;
              state_d = VERIFY;
            end
          end else begin
            bit_cnt_d = cnt_inc;
          end
        end

        VERIFY: begin
          if (BIT_I == fb) begin
            lfsr_d = lfsr_step;
            if (cnt_inc == VERIFY_LEN_C) begin
              state_d   = LOCKED;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = cnt_inc;
            end
          end else begin
            // The mismatching bit is dropped; the next hunt starts clean.
            state_d   = HUNT;
            hunt_sr_d = '0;
            bit_cnt_d = '0;
          end
        end

        LOCKED: begin
          bit_o_d   = BIT_I ^ fb;
          valid_o_d = 1'b1;
          lfsr_d    = lfsr_step;
        end

        default: begin
          state_d   = HUNT;
          hunt_sr_d = '0;
          bit_cnt_d = '0;
        end
      endcase
    end

    lock_o_d = (state_d == LOCKED);
  end

  assign BIT_O   = bit_o_q;
  assign VALID_O = valid_o_q;
  assign LOCK_O  = lock_o_q;

endmodule : descrambler_sync

// File: tb/tb_descrambler_sync.sv
// tb/tb_descrambler_sync.sv - randomized self-checking bench for descrambler_sync

module tb_descrambler_sync;

  localparam int VLEN = 16;
  localparam int ACQ  = 12 + VLEN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] bit_i, valid_i, resync_i;
  logic       bo0, bo1, vo0, vo1, lo0, lo1;

  always #5 clk = ~clk;

  // Unit 0 starts locked from the seed, unit 1 starts hunting.
  descrambler_sync #(.SEED(12'h14D), .START_LOCKED(1'b1), .VERIFY_LEN(VLEN)) dut_l (
    .CLK_I (clk), .RST_N_I (rst_n),
    .BIT_I (bit_i[0]), .VALID_I (valid_i[0]), .RESYNC_I (resync_i[0]),
    .BIT_O (bo0), .VALID_O (vo0), .LOCK_O (lo0)
  );

  descrambler_sync #(.SEED(12'h14D), .START_LOCKED(1'b0), .VERIFY_LEN(VLEN)) dut_h (
    .CLK_I (clk), .RST_N_I (rst_n),
    .BIT_I (bit_i[1]), .VALID_I (valid_i[1]), .RESYNC_I (resync_i[1]),
    .BIT_O (bo1), .VALID_O (vo1), .LOCK_O (lo1)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] tx_lfsr [2];
  bit          last_pt [2];

  task automatic check_eq(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_of(input int u);
    return (u == 0) ? bo0 : bo1;
  endfunction
  function automatic logic valid_of(input int u);
    return (u == 0) ? vo0 : vo1;
  endfunction
  function automatic logic lock_of(input int u);
    return (u == 0) ? lo0 : lo1;
  endfunction

  // Transmitter model: line bit = plaintext ^ (q[10]^q[3]^q[0]), then shift.
  task automatic scramble(input int u, input bit pt, output bit sb);
    bit fb;
    fb         = tx_lfsr[u][10] ^ tx_lfsr[u][3] ^ tx_lfsr[u][0];
    sb         = pt ^ fb;
    tx_lfsr[u] = {fb, tx_lfsr[u][11:1]};
  endtask

  task automatic tick(input int u, input bit b, input bit v, input bit r);
    bit_i       = '0;
    valid_i     = '0;
    resync_i    = '0;
    bit_i[u]    = b;
    valid_i[u]  = v;
    resync_i[u] = r;
    @(posedge clk);
    #1;
  endtask

  // One cycle while locked: payload recovered with 1-cycle latency.
  task automatic send(input int u, input bit pt, input bit v, input string tag);
    bit sb;
    sb = $urandom;
    if (v) scramble(u, pt, sb);
    tick(u, sb, v, 1'b0);
    if (v) last_pt[u] = pt;
    check_eq({tag, ".lock"},  lock_of(u),  1'b1);
    check_eq({tag, ".valid"}, valid_of(u), v);
    check_eq({tag, ".bit"},   bit_of(u),   last_pt[u]);
  endtask

  // Idle preamble with random gaps; lock must appear on exactly the ACQ-th
  // valid bit and no output may be produced meanwhile.
  task automatic idle_acquire(input int u, input int gap_pct, input string tag);
    int n = 0;
    int cycles = 0;
    bit sb;
    bit v;
    while (n < ACQ && cycles < 2000) begin
      v  = ($urandom_range(99) >= gap_pct);
      sb = $urandom;
      if (v) begin
        scramble(u, 1'b0, sb);
        n++;
      end
      tick(u, sb, v, 1'b0);
      cycles++;
      check_eq({tag, ".lock"},  lock_of(u),  (n == ACQ));
      check_eq({tag, ".valid"}, valid_of(u), 1'b0);
      check_eq({tag, ".hold"},  bit_of(u),   last_pt[u]);
    end
    check_eq({tag, ".budget"}, (n == ACQ), 1'b1);
  endtask

  task automatic resync(input int u, input string tag);
    tick(u, 1'(($urandom)), 1'b1, 1'b1);
    check_eq({tag, ".lock"},  lock_of(u),  1'b0);
    check_eq({tag, ".valid"}, valid_of(u), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit sb;
    rst_n      = 1'b0;
    bit_i      = '0;
    valid_i    = '0;
    resync_i   = '0;
    tx_lfsr[0] = 12'h14D;
    tx_lfsr[1] = 12'hABC;
    last_pt[0] = 1'b0;
    last_pt[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check_eq("rst.lock_l",  lo0, 1'b1);
    check_eq("rst.lock_h",  lo1, 1'b0);
    check_eq("rst.valid_l", vo0, 1'b0);
    check_eq("rst.valid_h", vo1, 1'b0);
    check_eq("rst.bit_l",   bo0, 1'b0);
    check_eq("rst.bit_h",   bo1, 1'b0);
    rst_n = 1'b1;

    // Locked from seed: three idle zeros then random payload.
    for (int i = 0; i < 3; i++) send(0, 1'b0, 1'b1, "seed.idle");
    for (int i = 0; i < 40; i++) send(0, 1'(($urandom)), 1'b1, "seed.pay");

    // Hunt acquisition from an unknown transmitter seed.
    idle_acquire(1, 0, "hunt.acq");
    for (int i = 0; i < 40; i++) send(1, 1'(($urandom)), 1'b1, "hunt.pay");

    // VALID_I gaps while locked.
    for (int i = 0; i < 60; i++) send(1, 1'(($urandom)), 1'(($urandom)), "gap.pay");

    // RESYNC_I together with VALID_I, then gapped reacquisition.
    resync(1, "rsy");
    idle_acquire(1, 30, "rsy.acq");
    for (int i = 0; i < 20; i++) send(1, 1'(($urandom)), 1'b1, "rsy.pay");

    // Verify failure on the 5th predicted bit, then a clean retry.
    resync(1, "vfy.rsy");
    for (int i = 0; i < 17; i++) begin
      scramble(1, 1'b0, sb);
      if (i == 16) sb = ~sb;
      tick(1, sb, 1'b1, 1'b0);
      check_eq("vfy.lock",  lo1, 1'b0);
      check_eq("vfy.valid", vo1, 1'b0);
    end
    idle_acquire(1, 0, "vfy.acq");
    for (int i = 0; i < 20; i++) send(1, 1'(($urandom)), 1'b1, "vfy.pay");

    // Twelve raw zero bits capture an all-zero LFSR, which must be rejected.
    resync(1, "zero.rsy");
    for (int i = 0; i < 12; i++) begin
      tick(1, 1'b0, 1'b1, 1'b0);
      check_eq("zero.lock",  lo1, 1'b0);
      check_eq("zero.valid", vo1, 1'b0);
    end
    idle_acquire(1, 20, "zero.acq");
    for (int i = 0; i < 10; i++) send(1, 1'(($urandom)), 1'b1, "zero.pay");

    // Asynchronous reset in the middle of locked payload.
    send(0, 1'b1, 1'b1, "arst.pre");
    rst_n = 1'b0;
    #2;
    check_eq("arst.valid_l", vo0, 1'b0);
    check_eq("arst.bit_l",   bo0, 1'b0);
    check_eq("arst.lock_l",  lo0, 1'b1);
    check_eq("arst.lock_h",  lo1, 1'b0);
    #2;
    rst_n      = 1'b1;
    tx_lfsr[0] = 12'h14D;
    tx_lfsr[1] = 12'h5A5;
    last_pt[0] = 1'b0;
    last_pt[1] = 1'b0;
    for (int i = 0; i < 30; i++) send(0, 1'(($urandom)), 1'(($urandom)), "arst.pay");
    idle_acquire(1, 40, "arst.acq");
    for (int i = 0; i < 10; i++) send(1, 1'(($urandom)), 1'b1, "arst.hpay");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_descrambler_sync

// File: doc/descrambler_sync.md
Name: descrambler_sync

Overview:
- Receive-side counterpart of the team's additive 12-bit scrambler.
- Polynomial taps: feedback = q[10]^q[3]^q[0]. Shift: q <= {feedback, q[11:1]}.
- Recovers keystream alignment either from a common reset seed or by hunting on an idle (all-zero plaintext) preamble. Once locked, XORs the keystream off the received serial bits.
- Sits between the serial line receiver and the deframer.

Parameters:
- SEED, 12'h14D, LFSR value loaded at reset; must match the transmitter seed.
- START_LOCKED, 1'b1, 1 = enter LOCKED from reset using SEED; 0 = enter HUNT from reset.
- VERIFY_LEN, 16, consecutive correctly predicted idle bits required in VERIFY before LOCKED; range 1..255.

Ports:
- CLK_I  input  1  clock.
- RST_N_I  input  1  reset, asynchronous, active-low.
- BIT_I  input  1  received scrambled bit; qualified by VALID_I.
- VALID_I  input  1  BIT_I valid this cycle. No backpressure.
- RESYNC_I  input  1  single-cycle pulse; forces HUNT.
- BIT_O  output  1  descrambled bit; registered.
- VALID_O  output  1  BIT_O valid; registered.
- LOCK_O  output  1  high while in LOCKED; registered.

Behaviour:
- Reset (async): lfsr=SEED; hunt_sr=0; bit_cnt=0; BIT_O=0; VALID_O=0.
- Reset state: state=LOCKED and LOCK_O=1 if START_LOCKED=1, otherwise state=HUNT and LOCK_O=0.
- Define fb = lfsr[10]^lfsr[3]^lfsr[0]. lfsr only advances on cycles with VALID_I=1; no state changes on VALID_I=0 cycles (except RESYNC_I).
- HUNT, on each VALID_I:
  - hunt_sr <= {BIT_I, hunt_sr[11:1]}; bit_cnt++.
  - On the 12th bit: lfsr <= {BIT_I, hunt_sr[11:1]}, bit_cnt<=0, go to VERIFY.
  - Rationale: with zero plaintext, the transmitter's LFSR equals its last 12 output bits.
- VERIFY, on each VALID_I:
  - If BIT_I == fb: lfsr <= {fb, lfsr[11:1]}, bit_cnt++. On reaching VERIFY_LEN, go to LOCKED with bit_cnt<=0.
  - If BIT_I != fb: go to HUNT with hunt_sr<=0, bit_cnt<=0. The mismatching bit is not reused.
- LOCKED, on each VALID_I: BIT_O <= BIT_I ^ fb; VALID_O <= 1; lfsr <= {fb, lfsr[11:1]}.
- LOCKED, on VALID_I=0: VALID_O <= 0. BIT_O holds its last value.
- Output latency: 1 cycle from VALID_I to VALID_O.
- VALID_O is 0 in HUNT and VERIFY. The first VALID_O follows the first VALID_I seen in LOCKED; the bit that completes VERIFY is not output.
- LOCK_O <= (next state == LOCKED). It rises in the same cycle VALID_O could first be asserted.
- RESYNC_I has priority over VALID_I in any state: go to HUNT, hunt_sr<=0, bit_cnt<=0, VALID_O<=0, LOCK_O<=0. The lfsr is not reloaded. RESYNC_I in HUNT restarts the count.
- bit_cnt: 8 bits, saturating behaviour not needed (bounded by max(12, VERIFY_LEN)).
- lfsr is never all-zero when fed from SEED. If hunting captures 12'h000, go to HUNT again rather than VERIFY (a degenerate all-zero lfsr is illegal).
- Reset mid-operation: immediate return to the reset values above, with no partial output.

Decomposition:
- Package scrambler_pkg holds:
  - LFSR_W=12.
  - TAP mask 12'b0100_0000_1001 (bits 10, 3, 0).
  - DEFAULT_SEED=12'h14D.
  - typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} dsc_state_t.
  - Function lfsr_fb(logic [11:0]). The scrambler shares this function.
- Sub-module lfsr12_step: a combinational next-state/fb generator, used by both the scrambler and this block.
- FSM and datapath stay in descrambler_sync.

Test Plan:
- Locked-from-seed: START_LOCKED=1, drive BIT_I = scrambler output for plaintext 0,0,0 (scrambled 0,0,1) with VALID_I=1 -> BIT_O=0,0,0, VALID_O=1 from cycle 1, LOCK_O=1 throughout.
- Hunt acquisition: START_LOCKED=0, transmitter seeded 12'hABC, sends 12+16 idle-zero scrambled bits then random payload -> LOCK_O rises after exactly 28 valid bits; payload recovered bit-exact with 1-cycle latency.
- Verify failure: during VERIFY, flip the 5th predicted bit -> state returns to HUNT, LOCK_O stays 0, no VALID_O; a clean 28-bit idle retry then locks.
- VALID_I gaps: random 50% VALID_I while LOCKED -> output stream identical to the gapless run; VALID_O mirrors VALID_I delayed 1 cycle.
- RESYNC_I and VALID_I asserted in the same cycle while LOCKED -> next cycle LOCK_O=0, VALID_O=0, state HUNT; relock after 28 idle bits.
- Async reset mid-LOCKED payload -> LOCK_O, VALID_O and lfsr take reset values without waiting for a clock edge; with START_LOCKED=1, decoding resumes correctly against a transmitter also reset.
